// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl shared definitions
// access sizes, FSM states, lane masks
package data_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_HI   = 4'b1100;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_B0   = 4'b0001;

   function automatic size_e dec_size(
      input logic b,
      input logic h
   );
      size_e s;
      s = SZ_WORD;
      unique case (1'b1)
         b:       s = SZ_BYTE;
         h:       s = SZ_HALF;
         default: s = SZ_WORD;
      endcase
      return s;
   endfunction

   function automatic logic is_aligned(
      input size_e      s,
      input logic [1:0] a
   );
      logic ok;
      ok = 1'b1;
      unique case (s)
         SZ_WORD: ok = (a == 2'b00);
         SZ_HALF: ok = ~a[0];
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl external memory bus
// master = controller, slave = memory
interface data_mem_ctrl_if #(
   parameter int ADDR_W = 30
);
   logic [31:0]       DataMem_In;
   logic              DataMem_Ready;
   logic              DataMem_Read;
   logic [3:0]        DataMem_Write;
   logic [ADDR_W-1:0] DataMem_Address;
   logic [31:0]       DataMem_Out;

   modport master (
      input  DataMem_In,
      input  DataMem_Ready,
      output DataMem_Read,
      output DataMem_Write,
      output DataMem_Address,
      output DataMem_Out
   );

   modport slave (
      output DataMem_In,
      output DataMem_Ready,
      input  DataMem_Read,
      input  DataMem_Write,
      input  DataMem_Address,
      input  DataMem_Out
   );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane shift/enables
// and load lane select/extension
module mem_lane_align
   import data_mem_ctrl_pkg::*;
#(
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  size_e       st_size,
   input  logic [1:0]  st_addr,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_lanes,
   input  size_e       ld_size,
   input  logic [1:0]  ld_addr,
   input  logic        ld_sign,
   input  logic [31:0] ld_raw,
   output logic [31:0] ld_data
);

   // physical byte lane holding a given byte offset
   function automatic logic [1:0] lane(
      input logic [1:0] a
   );
      return LITTLE_ENDIAN ? a : ~a;
   endfunction

   logic [1:0]  sl;
   logic [1:0]  ll;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   assign sl   = lane(st_addr);
   assign ll   = lane(ld_addr);
   assign ld_b = ld_raw[{ll, 3'b000} +: 8];
   assign ld_h = ll[1] ? ld_raw[31:16]
                       : ld_raw[15:0];

   always_comb begin
      st_be    = BE_WORD;
      st_lanes = st_data;
      unique case (st_size)
         SZ_BYTE: begin
            st_be    = BE_B0 << sl;
            st_lanes = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_be    = sl[1] ? BE_HI : BE_LO;
            st_lanes = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = BE_WORD;
            st_lanes = st_data;
         end
      endcase
   end

   always_comb begin
      ld_data = ld_raw;
      unique case (ld_size)
         SZ_BYTE:
            ld_data = {{24{ld_sign & ld_b[7]}}, ld_b};
         SZ_HALF:
            ld_data = {{16{ld_sign & ld_h[15]}}, ld_h};
         default:
            ld_data = ld_raw;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store/LL/SC
// controller with memory handshake and stall
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W        = 30,
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic        MEM_Byte,
   input  logic        MEM_Half,
   input  logic        MEM_SignExtend,
   input  logic        MEM_LLSC,
   input  logic [31:0] MEM_Address,
   input  logic [31:0] MEM_WriteData,
   input  logic        MEM_Exception,
   input  logic        Eret,
   input  logic        IF_Stall,
   output logic [31:0] M_ReadData,
   output logic        M_Stall_Controller,
   output logic        EXC_AdEL,
   output logic        EXC_AdES,
   data_mem_ctrl_if.master dmem
);

   state_e state_q, state_d;

   size_e       size;
   logic        aligned;
   logic        is_ll, is_sc;
   logic        sc_try, sc_fail;
   logic        req;
   logic        start, finish;
   logic [3:0]  st_be;
   logic [31:0] st_lanes;
   logic [31:0] ld_data;

   logic              ll_bit;
   logic              rd_q;
   logic [3:0]        we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       out_q;
   size_e             ld_size_q;
   logic [1:0]        ld_addr_q;
   logic              ld_sign_q;
   logic              ll_q, sc_q;

   assign size    = dec_size(MEM_Byte, MEM_Half);
   assign aligned = is_aligned(size, MEM_Address[1:0]);
   assign is_ll   = MEM_MemRead & MEM_LLSC;
   assign is_sc   = MEM_MemWrite & MEM_LLSC;
   assign sc_try  = is_sc & ~MEM_Exception & aligned;
   assign sc_fail = sc_try & ~ll_bit;

   assign req = (MEM_MemRead | MEM_MemWrite)
              & ~MEM_Exception & aligned
              & ~(is_sc & ~ll_bit);

   assign EXC_AdEL = MEM_MemRead & ~aligned;
   assign EXC_AdES = MEM_MemWrite & ~aligned;

   assign start  = (state_q == S_IDLE) & req;
   assign finish = (state_q == S_ACCESS)
                 & dmem.DataMem_Ready;

   mem_lane_align #(
      .LITTLE_ENDIAN(LITTLE_ENDIAN)
   ) u_align (
      .st_size (size),
      .st_addr (MEM_Address[1:0]),
      .st_data (MEM_WriteData),
      .st_be   (st_be),
      .st_lanes(st_lanes),
      .ld_size (ld_size_q),
      .ld_addr (ld_addr_q),
      .ld_sign (ld_sign_q),
      .ld_raw  (dmem.DataMem_In),
      .ld_data (ld_data)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d            = state_q;
      M_Stall_Controller = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            M_Stall_Controller = req;
            if (req) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            M_Stall_Controller = 1'b1;
            if (dmem.DataMem_Ready) state_d = S_DONE;
         end
         S_DONE: begin
            if (!IF_Stall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_q       <= 1'b0;
         we_q       <= '0;
         addr_q     <= '0;
         out_q      <= '0;
         ld_size_q  <= SZ_WORD;
         ld_addr_q  <= '0;
         ld_sign_q  <= 1'b0;
         ll_q       <= 1'b0;
         sc_q       <= 1'b0;
         M_ReadData <= '0;
      end else begin
         if (start) begin
            rd_q      <= MEM_MemRead;
            we_q      <= MEM_MemWrite ? st_be : 4'b0000;
            addr_q    <= MEM_Address[ADDR_W+1:2];
            out_q     <= st_lanes;
            ld_size_q <= size;
            ld_addr_q <= MEM_Address[1:0];
            ld_sign_q <= MEM_SignExtend;
            ll_q      <= is_ll;
            sc_q      <= is_sc;
         end
         if (finish) begin
            rd_q <= 1'b0;
            we_q <= '0;
            if (sc_q)      M_ReadData <= 32'd1;
            else if (rd_q) M_ReadData <= ld_data;
         end
         if ((state_q == S_IDLE) && sc_fail)
            M_ReadData <= '0;
      end
   end

   // Eret wins over an LL completing in the same cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         ll_bit <= 1'b0;
      else if (Eret)
         ll_bit <= 1'b0;
      else if ((state_q == S_IDLE) && sc_try)
         ll_bit <= 1'b0;
      else if (finish && ll_q)
         ll_bit <= 1'b1;
   end

   assign dmem.DataMem_Read    = rd_q;
   assign dmem.DataMem_Write   = we_q;
   assign dmem.DataMem_Address = addr_q;
   assign dmem.DataMem_Out     = out_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vectors for
// data_mem_ctrl with hand-computed results
module tb_data_mem_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        MEM_MemRead, MEM_MemWrite;
   logic        MEM_Byte, MEM_Half;
   logic        MEM_SignExtend, MEM_LLSC;
   logic [31:0] MEM_Address, MEM_WriteData;
   logic        MEM_Exception, Eret, IF_Stall;
   logic [31:0] M_ReadData;
   logic        M_Stall_Controller;
   logic        EXC_AdEL, EXC_AdES;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   data_mem_ctrl_if #(.ADDR_W(30)) dmem ();

   data_mem_ctrl #(
      .ADDR_W       (30),
      .LITTLE_ENDIAN(1'b1)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .MEM_MemRead       (MEM_MemRead),
      .MEM_MemWrite      (MEM_MemWrite),
      .MEM_Byte          (MEM_Byte),
      .MEM_Half          (MEM_Half),
      .MEM_SignExtend    (MEM_SignExtend),
      .MEM_LLSC          (MEM_LLSC),
      .MEM_Address       (MEM_Address),
      .MEM_WriteData     (MEM_WriteData),
      .MEM_Exception     (MEM_Exception),
      .Eret              (Eret),
      .IF_Stall          (IF_Stall),
      .M_ReadData        (M_ReadData),
      .M_Stall_Controller(M_Stall_Controller),
      .EXC_AdEL          (EXC_AdEL),
      .EXC_AdES          (EXC_AdES),
      .dmem              (dmem)
   );

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h",
                  tag, got, exp);
      end
   endtask

   task automatic idle_in();
      MEM_MemRead        = 1'b0;
      MEM_MemWrite       = 1'b0;
      MEM_Byte           = 1'b0;
      MEM_Half           = 1'b0;
      MEM_SignExtend     = 1'b0;
      MEM_LLSC           = 1'b0;
      MEM_Address        = '0;
      MEM_WriteData      = '0;
      MEM_Exception      = 1'b0;
      Eret               = 1'b0;
      IF_Stall           = 1'b0;
      dmem.DataMem_Ready = 1'b0;
      dmem.DataMem_In    = '0;
   endtask

   task automatic drive(
      input logic        rd,
      input logic        wr,
      input logic        b,
      input logic        h,
      input logic        se,
      input logic        llsc,
      input logic [31:0] addr,
      input logic [31:0] wdata
   );
      MEM_MemRead    = rd;
      MEM_MemWrite   = wr;
      MEM_Byte       = b;
      MEM_Half       = h;
      MEM_SignExtend = se;
      MEM_LLSC       = llsc;
      MEM_Address    = addr;
      MEM_WriteData  = wdata;
   endtask

   // memory responder; returns at negedge+1 once stall and strobes drop
   task automatic run(
      input  int          waits,
      input  logic [31:0] rdata,
      output int          st,
      output int          rd,
      output logic [31:0] a,
      output logic [3:0]  we,
      output logic [31:0] dout
   );
      int w;
      int g;
      st = 0; rd = 0; a = '0; we = '0; dout = '0;
      w = 0; g = 0;
      #1;
      while ((M_Stall_Controller || dmem.DataMem_Read
              || (dmem.DataMem_Write != 4'b0000))
             && g < 40) begin
         st += int'(M_Stall_Controller);
         rd += int'(dmem.DataMem_Read);
         dmem.DataMem_Ready = 1'b0;
         if (dmem.DataMem_Read
             || (dmem.DataMem_Write != 4'b0000)) begin
            a    = {2'b00, dmem.DataMem_Address};
            we   = dmem.DataMem_Write;
            dout = dmem.DataMem_Out;
            if (w == waits) begin
               dmem.DataMem_Ready = 1'b1;
               dmem.DataMem_In    = rdata;
            end else begin
               w++;
            end
         end
         @(negedge clock);
         #1;
         g++;
      end
      dmem.DataMem_Ready = 1'b0;
      check("bounded", {31'd0, g < 40}, 32'd1);
   endtask

   task automatic end_req();
      idle_in();
      @(negedge clock);
   endtask

   int          st, rd;
   logic [31:0] a, dout;
   logic [3:0]  we;

   initial begin
      reset_n = 1'b0;
      idle_in();
      #12;
      check("rst_rdata", M_ReadData, 32'h0);
      check("rst_read", {31'd0, dmem.DataMem_Read}, 32'd0);
      check("rst_write", {28'd0, dmem.DataMem_Write}, 32'd0);
      check("rst_addr", {2'b00, dmem.DataMem_Address}, 32'd0);
      check("rst_out", dmem.DataMem_Out, 32'd0);
      check("rst_stall", {31'd0, M_Stall_Controller}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // word load, two wait states
      drive(1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
      run(2, 32'hDEADBEEF, st, rd, a, we, dout);
      check("lw_stall", st, 4);
      check("lw_reads", rd, 3);
      check("lw_addr", a, 32'h40);
      check("lw_data", M_ReadData, 32'hDEADBEEF);
      end_req();

      // signed and unsigned byte loads at lane 3
      drive(1, 0, 1, 0, 1, 0, 32'h103, 32'h0);
      run(0, 32'h80123456, st, rd, a, we, dout);
      check("lb_stall", st, 2);
      check("lb_data", M_ReadData, 32'hFFFFFF80);
      end_req();
      drive(1, 0, 1, 0, 0, 0, 32'h103, 32'h0);
      run(0, 32'h80123456, st, rd, a, we, dout);
      check("lbu_data", M_ReadData, 32'h00000080);
      end_req();

      // signed halfword at upper half
      drive(1, 0, 0, 1, 1, 0, 32'h102, 32'h0);
      run(0, 32'h9ABC1234, st, rd, a, we, dout);
      check("lh_data", M_ReadData, 32'hFFFF9ABC);
      end_req();

      // half store to upper half
      drive(0, 1, 0, 1, 0, 0, 32'h202, 32'h0000ABCD);
      run(0, 32'h0, st, rd, a, we, dout);
      check("sh_we", {28'd0, we}, 32'hC);
      check("sh_out_hi", dout >> 16, 32'hABCD);
      check("sh_addr", a, 32'h80);
      check("sh_keep", M_ReadData, 32'hFFFF9ABC);
      end_req();

      // byte store to lane 1
      drive(0, 1, 1, 0, 0, 0, 32'h305, 32'h000000A5);
      run(0, 32'h0, st, rd, a, we, dout);
      check("sb_we", {28'd0, we}, 32'h2);
      check("sb_out", dout, 32'hA5A5A5A5);
      end_req();

      // unaligned word load and half store
      drive(1, 0, 0, 0, 0, 0, 32'h201, 32'h0);
      #1;
      check("adel", {31'd0, EXC_AdEL}, 32'd1);
      check("adel_stall", {31'd0, M_Stall_Controller}, 32'd0);
      @(negedge clock);
      #1;
      check("adel_read", {31'd0, dmem.DataMem_Read}, 32'd0);
      drive(0, 1, 0, 1, 0, 0, 32'h203, 32'h0);
      #1;
      check("ades", {31'd0, EXC_AdES}, 32'd1);
      check("ades_adel", {31'd0, EXC_AdEL}, 32'd0);
      end_req();

      // flushed load issues nothing
      drive(1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
      MEM_Exception = 1'b1;
      run(0, 32'h0, st, rd, a, we, dout);
      check("exc_stall", st, 0);
      end_req();

      // LL then SC succeeds; second SC fails
      drive(1, 0, 0, 0, 0, 1, 32'h10, 32'h0);
      run(0, 32'h11112222, st, rd, a, we, dout);
      check("ll_data", M_ReadData, 32'h11112222);
      end_req();
      drive(0, 1, 0, 0, 0, 1, 32'h10, 32'h55);
      run(0, 32'h0, st, rd, a, we, dout);
      check("sc_we", {28'd0, we}, 32'hF);
      check("sc_ok", M_ReadData, 32'd1);
      end_req();
      drive(0, 1, 0, 0, 0, 1, 32'h10, 32'h66);
      run(0, 32'h0, st, rd, a, we, dout);
      check("sc2_stall", st, 0);
      check("sc2_we", {28'd0, we}, 32'h0);
      @(negedge clock);
      #1;
      check("sc2_res", M_ReadData, 32'd0);
      end_req();

      // LL, Eret, SC fails
      drive(1, 0, 0, 0, 0, 1, 32'h20, 32'h0);
      run(0, 32'h00000077, st, rd, a, we, dout);
      check("ll2_data", M_ReadData, 32'h77);
      end_req();
      Eret = 1'b1;
      @(negedge clock);
      Eret = 1'b0;
      drive(0, 1, 0, 0, 0, 1, 32'h20, 32'h1);
      run(0, 32'h0, st, rd, a, we, dout);
      check("sc3_stall", st, 0);
      @(negedge clock);
      #1;
      check("sc3_res", M_ReadData, 32'd0);
      end_req();

      // completion while front end is stalled
      drive(1, 0, 0, 0, 0, 0, 32'h300, 32'h0);
      IF_Stall = 1'b1;
      run(1, 32'h12345678, st, rd, a, we, dout);
      check("ifs_stall", st, 3);
      check("ifs_reads", rd, 2);
      rd = 0;
      st = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         #1;
         rd += int'(dmem.DataMem_Read);
         st += int'(M_Stall_Controller);
         check("ifs_hold", M_ReadData, 32'h12345678);
      end
      check("ifs_extra_rd", rd, 0);
      check("ifs_extra_st", st, 0);
      end_req();
      #1;
      check("ifs_idle", {31'd0, M_Stall_Controller}, 32'd0);

      // reset in the middle of an access
      @(negedge clock);
      drive(1, 0, 0, 0, 0, 0, 32'h400, 32'h0);
      @(negedge clock);
      #1;
      check("mid_read", {31'd0, dmem.DataMem_Read}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("mr_read", {31'd0, dmem.DataMem_Read}, 32'd0);
      check("mr_addr", {2'b00, dmem.DataMem_Address}, 32'd0);
      check("mr_rdata", M_ReadData, 32'd0);
      idle_in();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      drive(1, 0, 0, 0, 0, 0, 32'h104, 32'h0);
      run(1, 32'hCAFEF00D, st, rd, a, we, dout);
      check("post_stall", st, 3);
      check("post_addr", a, 32'h41);
      check("post_data", M_ReadData, 32'hCAFEF00D);
      end_req();

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
